// File: rtl/button_event.sv
// Classifies a debounced button level into short, double and long press events.
// A single shared counter times both the hold duration and the release gap.
module button_event #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned LONG_MS  = 1000,
  parameter int unsigned GAP_MS   = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic short_press,
  output logic double_press,
  output logic long_press,
  output logic held
);

  localparam int unsigned CYC_PER_MS = CLK_FREQ / 1000;
  localparam int unsigned LONG_CYC   = CYC_PER_MS * LONG_MS;
  localparam int unsigned GAP_CYC    = CYC_PER_MS * GAP_MS;
  localparam int unsigned MAX_CYC    = (LONG_CYC > GAP_CYC) ? LONG_CYC : GAP_CYC;
  localparam int unsigned CW         = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StWaitGap,
    StPress2,
    StLong
  } state_e;

  state_e        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          btn_q;
  logic          rise;
  logic          fall;

  assign rise = btn & ~btn_q;
  assign fall = ~btn & btn_q;

  // Saturate rather than wrap; terminal compares normally leave the state first.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= StIdle;
      cnt          <= '0;
      btn_q        <= 1'b0;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;
      held         <= 1'b0;
    end else begin
      btn_q        <= btn;
      short_press  <= 1'b0;
      double_press <= 1'b0;
      long_press   <= 1'b0;

      unique case (state)
        StIdle: begin
          cnt <= '0;
          if (rise) begin
            state <= StPress1;
          end
        end

        StPress1: begin
          // Release beats the long-press threshold when both land together.
          if (fall) begin
            state <= StWaitGap;
            cnt   <= '0;
          end else if (btn && (cnt == LONG_LAST)) begin
            state      <= StLong;
            cnt        <= '0;
            long_press <= 1'b1;
            held       <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        StLong: begin
          if (fall) begin
            state <= StIdle;
            held  <= 1'b0;
          end
        end

        StWaitGap: begin
          // A second press beats the gap timeout when both land together.
          if (rise) begin
            state <= StPress2;
            cnt   <= '0;
          end else if (cnt == GAP_LAST) begin
            state       <= StIdle;
            cnt         <= '0;
            short_press <= 1'b1;
          end else begin
            cnt <= cnt_inc;
          end
        end

        StPress2: begin
          if (fall) begin
            state        <= StIdle;
            double_press <= 1'b1;
          end
        end

        default: begin
          state <= StIdle;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Scoreboard bench for button_event: expected events are queued with the cycle
// they must appear in and matched against the pulses the DUT produces.
module tb_button_event;

  localparam int LONG_CYC = 20;
  localparam int GAP_CYC  = 10;

  logic clk;
  logic rst_n;
  logic btn;
  logic short_press;
  logic double_press;
  logic long_press;
  logic held;

  typedef struct {
    int kind;  // 1 short, 2 double, 3 long
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_ev;
  int  cyc;
  int  checks;
  int  errors;
  int  held_from;
  int  held_to;
  int  mon_n;
  int  mon_kind;

  button_event #(
    .CLK_FREQ(10000),
    .LONG_MS (2),
    .GAP_MS  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .short_press (short_press),
    .double_press(double_press),
    .long_press  (long_press),
    .held        (held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc names the most recent rising edge; outputs are sampled on the falling edge.
  initial cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic push(input int kind, input int at);
    ev_t e;
    e.kind = kind;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_short"}, int'(short_press), 0);
    check({tag, "_double"}, int'(double_press), 0);
    check({tag, "_long"}, int'(long_press), 0);
    check({tag, "_held"}, int'(held), 0);
  endtask

  always @(negedge clk) begin
    mon_n = int'(short_press) + int'(double_press) + int'(long_press);
    if (mon_n > 1) begin
      check("onehot", mon_n, 1);
    end else if (mon_n == 1) begin
      mon_kind = short_press ? 1 : (double_press ? 2 : 3);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", mon_kind, 0);
      end else begin
        mon_ev = exp_q.pop_front();
        check("pulse_kind", mon_kind, mon_ev.kind);
        check("pulse_cycle", cyc, mon_ev.cyc);
      end
    end
    if (exp_q.size() > 0 && cyc > exp_q[0].cyc) begin
      check("missing_pulse", cyc, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    check("held", int'(held), int'(cyc >= held_from && cyc < held_to));
  end

  initial begin
    #200000;
    $display("FAIL watchdog at cycle %0d: got timeout expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int f;
    checks    = 0;
    errors    = 0;
    held_from = 0;
    held_to   = 0;
    rst_n     = 1'b0;
    btn       = 1'b0;
    #3;
    check_all_low("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold(1'b0, 3);

    // Single short press: pulse GAP_CYC edges after the fall edge.
    hold(1'b1, 5);
    f = cyc + 1;
    push(1, f + GAP_CYC);
    hold(1'b0, 20);

    // Double press.
    hold(1'b1, 5);
    hold(1'b0, 4);
    hold(1'b1, 5);
    f = cyc + 1;
    push(2, f);
    hold(1'b0, 20);

    // Long press held 30 cycles.
    r = cyc + 1;
    push(3, r + LONG_CYC);
    held_from = r + LONG_CYC;
    held_to   = r + 30;
    hold(1'b1, 30);
    hold(1'b0, 10);

    // Second rise exactly on the last gap cycle still makes a double.
    hold(1'b1, 5);
    hold(1'b0, GAP_CYC);
    hold(1'b1, 3);
    f = cyc + 1;
    push(2, f);
    hold(1'b0, 20);

    // Second rise one cycle too late: two separate shorts.
    hold(1'b1, 5);
    f = cyc + 1;
    push(1, f + GAP_CYC);
    hold(1'b0, GAP_CYC + 1);
    hold(1'b1, 5);
    f = cyc + 1;
    push(1, f + GAP_CYC);
    hold(1'b0, 20);

    // Fall on the last hold cycle stays a short press.
    hold(1'b1, LONG_CYC);
    f = cyc + 1;
    push(1, f + GAP_CYC);
    hold(1'b0, 20);

    // One more cycle of hold makes it long, held for a single cycle.
    r = cyc + 1;
    push(3, r + LONG_CYC);
    held_from = r + LONG_CYC;
    held_to   = r + LONG_CYC + 1;
    hold(1'b1, LONG_CYC + 1);
    hold(1'b0, 10);

    // Long second press is still only a double.
    hold(1'b1, 5);
    hold(1'b0, 4);
    hold(1'b1, 40);
    f = cyc + 1;
    push(2, f);
    hold(1'b0, 20);

    // Asynchronous reset in the middle of a long hold.
    r = cyc + 1;
    push(3, r + LONG_CYC);
    held_from = r + LONG_CYC;
    held_to   = r + 1000;
    hold(1'b1, 25);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("async_rst_long");
    held_to = cyc;
    hold(1'b0, 2);
    rst_n = 1'b1;
    hold(1'b0, 40);
    check("after_rst_long_queue", exp_q.size(), 0);

    // Reset during the gap discards the pending short press.
    hold(1'b1, 5);
    hold(1'b0, 4);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_low("async_rst_gap");
    hold(1'b0, 2);
    rst_n = 1'b1;
    hold(1'b0, 30);

    // Button already high at reset release counts as a rise.
    #2;
    rst_n = 1'b0;
    hold(1'b1, 2);
    rst_n = 1'b1;
    hold(1'b1, 5);
    f = cyc + 1;
    push(1, f + GAP_CYC);
    hold(1'b0, 20);

    check("final_queue", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_event.md
BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning clk frequency in Hz; CLK_FREQ/1000 SHALL be an integer >= 1.
REQ-002 SHALL have parameter LONG_MS, default 1000, meaning the hold time in ms that classifies a press as long.
REQ-003 SHALL have parameter GAP_MS, default 250, meaning the maximum release gap in ms between the two presses of a double press.
REQ-004 SHALL have port clk, input, 1, the single clock for the block.
REQ-005 SHALL have port rst_n, input, 1, the reset; it SHALL be asynchronous and active-low.
REQ-006 SHALL have port btn, input, 1, a debounced active-high button level synchronous to clk (the debouncer output).
REQ-007 SHALL have port short_press, output, 1, a one-cycle pulse for a single short press.
REQ-008 SHALL have port double_press, output, 1, a one-cycle pulse for two short presses within the gap.
REQ-009 SHALL have port long_press, output, 1, a one-cycle pulse when the hold time reaches LONG_MS.
REQ-010 SHALL have port held, output, 1, a level that is high while a long press is still held.

Function
REQ-011 SHALL derive LONG_CYC = (CLK_FREQ/1000)*LONG_MS and GAP_CYC = (CLK_FREQ/1000)*GAP_MS; the counter width SHALL be $clog2(max(LONG_CYC,GAP_CYC)+1), with no wrap.
REQ-012 SHALL register btn into btn_q every cycle; rise = btn & ~btn_q; fall = ~btn & btn_q.
REQ-013 SHALL implement FSM states IDLE, PRESS1, WAIT_GAP, PRESS2, LONG, plus one shared counter cnt.
REQ-014 In IDLE: rise -> PRESS1 with cnt=0; otherwise the FSM SHALL stay in IDLE.
REQ-015 In PRESS1: cnt increments each cycle; fall -> WAIT_GAP with cnt=0; cnt==LONG_CYC-1 with btn high -> LONG, asserting long_press.
REQ-016 In PRESS1, if fall and the cnt terminal condition occur in the same cycle, fall SHALL win (-> WAIT_GAP, no long_press).
REQ-017 In LONG: held=1; fall -> IDLE with no further pulse.
REQ-018 In WAIT_GAP: cnt increments; rise -> PRESS2; cnt==GAP_CYC-1 with no rise -> IDLE, asserting short_press.
REQ-019 In WAIT_GAP, if rise and the cnt terminal condition occur in the same cycle, rise SHALL win (-> PRESS2, no short_press).
REQ-020 In PRESS2: fall -> IDLE, asserting double_press; hold duration in PRESS2 SHALL be ignored (no long_press).
REQ-021 All outputs SHALL be registered; each pulse SHALL be high for exactly the one cycle following the clock edge at which the FSM takes the qualifying transition.
REQ-022 held SHALL rise in the same cycle long_press is high and fall in the cycle after the LONG->IDLE transition edge.
REQ-023 At most one of short_press, double_press, long_press SHALL be high in any cycle.
REQ-024 Each press sequence SHALL produce at most one event pulse.

Reset
REQ-025 rst_n low SHALL immediately force state=IDLE, cnt=0, btn_q=0, and short_press, double_press, long_press, held all =0, independent of clk.
REQ-026 An in-progress sequence SHALL be discarded on reset; no pulse SHALL follow reset release unless a new rise occurs.
REQ-027 If btn is high when rst_n releases, btn_q=0 makes it count as a rise, starting PRESS1.

Verification (CLK_FREQ=10000, LONG_MS=2, GAP_MS=1 -> LONG_CYC=20, GAP_CYC=10)
REQ-028 Reset: rst_n=0 mid-sequence with btn=1 -> all outputs 0 asynchronously; no pulse before a new rise.
REQ-029 Short: btn high 5 cycles, then low -> exactly one short_press pulse, 10 cycles after the fall-detect edge; no other pulses.
REQ-030 Double: btn high 5, low 4, high 5, low -> one double_press pulse the cycle after the second fall edge; short_press never asserted.
REQ-031 Long: btn high 30 cycles -> long_press one pulse 20 cycles after rise; held high from that cycle until one cycle after fall; no short/double.
REQ-032 Boundary: rise coinciding with WAIT_GAP cnt==9 -> PRESS2, then double_press on fall; fall coinciding with PRESS1 cnt==19 -> short_press path.
REQ-033 Mid-gap reset: rst_n pulsed low during WAIT_GAP -> no short_press emitted afterwards.
